// File: rtl/button_conditioner.sv
// Front-panel button conditioner: per-channel 2-FF synchroniser, debounce
// filter, stable level, and single-cycle press / release / long-press pulses
// for the board run-control FSM.
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int LONG_CYCLES     = 50000000,
    parameter int LONG_W          = 26
) (
    input  logic             fpgaclock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             any_press
);

    // Terminal counts: acceptance happens on the edge where the counter
    // already holds the terminal value, so a new level must persist
    // DEBOUNCE_CYCLES synchronised cycles; the hold counter saturates here.
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CYCLES - 1);

    logic [N_BTN-1:0]             s1_q, s2_q;
    logic [N_BTN-1:0]             lvl_q, lvl_d;
    logic [N_BTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BTN-1:0][LONG_W-1:0] hcnt_q, hcnt_d;
    logic [N_BTN-1:0]             long_done_q, long_done_d;
    logic [N_BTN-1:0]             press_q, press_d;
    logic [N_BTN-1:0]             release_q, release_d;
    logic [N_BTN-1:0]             long_q, long_d;
    logic                         any_q, any_d;

    // Debounce and long-press next-state; every channel is independent.
    always_comb begin
        lvl_d       = lvl_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        long_done_d = long_done_q;
        press_d     = '0;
        release_d   = '0;
        long_d      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            // Any return to the accepted level discards the partial count.
            if (s2_q[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_MAX) begin
                lvl_d[i]     = s2_q[i];
                cnt_d[i]     = '0;
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // Hold timing runs off the accepted level; long_done limits the
            // pulse to one per press however long the button stays down.
            if (lvl_q[i]) begin
                if (hcnt_q[i] != HOLD_MAX) begin
                    hcnt_d[i] = hcnt_q[i] + LONG_W'(1);
                end
                if ((hcnt_q[i] == HOLD_MAX) && !long_done_q[i]) begin
                    long_d[i]      = 1'b1;
                    long_done_d[i] = 1'b1;
                end
            end else begin
                hcnt_d[i]      = '0;
                long_done_d[i] = 1'b0;
            end
        end
        any_d = |press_d;
    end

    // State and output registers; reset clears everything, so a button held
    // through reset is re-debounced and reported as a fresh press.
    always_ff @(posedge fpgaclock) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            lvl_q       <= '0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            long_done_q <= '0;
            press_q     <= '0;
            release_q   <= '0;
            long_q      <= '0;
            any_q       <= 1'b0;
        end else begin
            s1_q        <= btn_raw;
            s2_q        <= s1_q;
            lvl_q       <= lvl_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            any_q       <= any_d;
        end
    end

    assign btn_level   = lvl_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_long    = long_q;
    assign any_press   = any_q;

endmodule
